seq_pattern_tx: RTL and testbench

- Serial pattern transmitter: the driving end for the team's serial Moore sequence detectors.
- Accepts a PAT_W-bit pattern word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with an optional one-cycle idle gap between repetitions.
- Used as on-chip stimulus and link source for the detector's `in` input. All outputs are Moore, decoded from registers only.

---
 rtl/seq_pattern_tx.sv | 91 +++++++++
 tb/tb_seq_pattern_tx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial MSB-first pattern transmitter with repeat count and optional idle gap
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rpt_cnt,
    input  logic             gap_en,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    localparam int BC_W = $clog2(PAT_W);
    localparam logic [BC_W-1:0] BIT_MAX = BC_W'(PAT_W - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d, sh_q, sh_d;
    logic [BC_W-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0]   rpt_q, rpt_d;
    logic               gap_q, gap_d;
    assign pat_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = state_q == SHIFT;
    assign out_bit   = out_valid & sh_q[PAT_W-1];
    assign done      = state_q == DONE;
    // state and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            rpt_q   <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            rpt_q   <= rpt_d;
            gap_q   <= gap_d;
        end
    end
    // next-state: accept in IDLE, shift out bits, reload or gap between repetitions
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        rpt_d   = rpt_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: if (pat_valid) begin
                pat_d   = pat_in;
                sh_d    = pat_in;
                rpt_d   = (rpt_cnt == '0) ? CNT_W'(1) : rpt_cnt;
                gap_d   = gap_en;
                bit_d   = BIT_MAX;
                state_d = SHIFT;
            end
            SHIFT: begin
                sh_d = {sh_q[PAT_W-2:0], 1'b0};
                if (bit_q != '0) begin
                    bit_d = bit_q - 1'b1;
                end else if (rpt_q > CNT_W'(1)) begin
                    rpt_d = rpt_q - 1'b1;
                    if (gap_q) begin
                        state_d = GAP;
                    end else begin
                        sh_d  = pat_q;
                        bit_d = BIT_MAX;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            GAP: begin
                sh_d    = pat_q;
                bit_d   = BIT_MAX;
                state_d = SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench for seq_pattern_tx (0/1 = data bit, 2 = gap cycle, 3 = done cycle)
module tb_seq_pattern_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pat_in = '0;
    logic [7:0] rpt_cnt = '0;
    logic       gap_en = 1'b0;
    logic       pat_valid = 1'b0;
    logic       pat_ready, out_bit, out_valid, busy, done;
    int         tests = 0;
    int         fails = 0;
    int         exp_q[$];

    seq_pattern_tx #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .pat_in(pat_in), .rpt_cnt(rpt_cnt), .gap_en(gap_en),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .out_bit(out_bit),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every busy cycle must match the next scoreboard entry
    always @(negedge clk) begin
        int act;
        chk("ready_vs_busy", int'(pat_ready), int'(!busy));
        if (busy) begin
            act = out_valid ? int'(out_bit) : done ? 3 : out_bit ? 4 : 2;
            if (exp_q.size() == 0) chk("unexpected_output", act, -1);
            else chk("stream", act, exp_q.pop_front());
        end else if (out_valid || done) begin
            chk("idle_outputs", int'({out_valid, done}), 0);
        end
    end

    function automatic void push_frame(input logic [3:0] pat, input int r, input logic gap);
        int rr;
        rr = (r == 0) ? 1 : r;
        for (int k = 0; k < rr; k++) begin
            for (int i = 3; i >= 0; i--) exp_q.push_back(int'(pat[i]));
            if (gap && k < rr - 1) exp_q.push_back(2);
        end
        exp_q.push_back(3);
    endfunction

    task automatic send(input logic [3:0] pat, input int r, input logic gap, input bit model);
        int n;
        n = 0;
        @(negedge clk);
        while (!pat_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pat_ready) chk("ready_timeout", 0, 1);
        pat_in = pat;
        rpt_cnt = 8'(r);
        gap_en = gap;
        pat_valid = 1'b1;
        if (model) push_frame(pat, r, gap);
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
        pat_in = ~pat;
        rpt_cnt = 8'd7;
        gap_en = ~gap;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !pat_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        pat_valid = 1'b1;
        pat_in = 4'b1111;
        rpt_cnt = 8'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_bit", int'(out_bit), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(pat_ready), 1);
        rst = 1'b0;
        pat_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_capture_in_reset", int'(busy), 0);
        send(4'b1011, 1, 1'b0, 1'b1);
        wait_idle();
        send(4'b1011, 3, 1'b0, 1'b1);
        wait_idle();
        send(4'b1011, 2, 1'b1, 1'b1);
        wait_idle();
        send(4'b1100, 0, 1'b1, 1'b1);
        wait_idle();
        send(4'b1001, 1, 1'b0, 1'b1);
        pat_in = 4'b0110;
        rpt_cnt = 8'd4;
        n = 0;
        do begin
            @(negedge clk);
            pat_valid = busy;
            if (busy) chk("ready_low_when_busy", int'(pat_ready), 0);
            n++;
        end while (busy && n < 50);
        pat_valid = 1'b0;
        wait_idle();
        send(4'b1011, 2, 1'b0, 1'b0);
        exp_q.push_back(1);
        exp_q.push_back(0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(pat_ready), 1);
        chk("abort_drained", exp_q.size(), 0);
        send(4'b0110, 1, 1'b0, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
